// File: rtl/i2c_fifo_sequencer.sv
// Sequences one I2C master transaction (START, address, data bytes, STOP) between the
// APB-side TX/RX FIFOs and the I2C byte engine. Define SEQ_TIMEOUT_EN to enable the TX stall timeout.
module i2c_fifo_sequencer #(
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 start,
  input  logic [6:0]           slave_addr,
  input  logic                 rw,
  input  logic [CNT_WIDTH-1:0] byte_count,
  input  logic                 tx_empty,
  input  logic [7:0]           tx_data,
  output logic                 tx_rd_en,
  input  logic                 rx_full,
  output logic                 rx_wr_en,
  output logic [7:0]           rx_data,
  output logic                 eng_valid,
  output logic [1:0]           eng_cmd,
  output logic [7:0]           eng_wdata,
  output logic                 eng_last,
  input  logic                 eng_ready,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rdata,
  input  logic                 eng_nack,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err_code
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_START   = 4'd1;
  localparam logic [3:0] ST_ADDR    = 4'd2;
  localparam logic [3:0] ST_WAIT_TX = 4'd3;
  localparam logic [3:0] ST_WRITE   = 4'd4;
  localparam logic [3:0] ST_WAIT_RX = 4'd5;
  localparam logic [3:0] ST_READ    = 4'd6;
  localparam logic [3:0] ST_STOP    = 4'd7;
  localparam logic [3:0] ST_FINISH  = 4'd8;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  logic [3:0]           state_q, state_d;
  logic [6:0]           addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic                 eng_valid_q, eng_valid_d;
  logic [1:0]           eng_cmd_q, eng_cmd_d;
  logic [7:0]           eng_wdata_q, eng_wdata_d;
  logic                 eng_last_q, eng_last_d;
  logic                 pend_q, pend_d;
  logic                 tx_rd_en_q, tx_rd_en_d;
  logic                 rx_wr_en_q, rx_wr_en_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 is_cmd_state;
  logic                 cmd_done;
  logic                 last_byte;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  function automatic logic [1:0] cmd_for(input logic [3:0] st);
    case (st)
      ST_START: cmd_for = CMD_START;
      ST_READ:  cmd_for = CMD_READ;
      ST_STOP:  cmd_for = CMD_STOP;
      default:  cmd_for = CMD_WRITE;
    endcase
  endfunction

  assign is_cmd_state = (state_q == ST_START) || (state_q == ST_ADDR) || (state_q == ST_WRITE) ||
                        (state_q == ST_READ)  || (state_q == ST_STOP);
  // Only a completion for an accepted, still-outstanding command is honoured.
  assign cmd_done  = pend_q && eng_done;
  assign last_byte = (cnt_q == CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    eng_valid_d = eng_valid_q;
    eng_cmd_d   = eng_cmd_q;
    eng_wdata_d = eng_wdata_q;
    eng_last_d  = eng_last_q;
    pend_d      = pend_q;
    tx_rd_en_d  = 1'b0;
    rx_wr_en_d  = 1'b0;
    rx_data_d   = rx_data_q;
`ifdef SEQ_TIMEOUT_EN
    to_cnt_d    = '0;
`endif

    // A command state raises its request once, on the first cycle with nothing in flight.
    if (eng_valid_q && eng_ready) begin
      eng_valid_d = 1'b0;
      pend_d      = 1'b1;
    end else if (is_cmd_state && !eng_valid_q && !pend_q) begin
      eng_valid_d = 1'b1;
      eng_cmd_d   = cmd_for(state_q);
      eng_last_d  = (state_q == ST_READ) && last_byte;
      if (state_q == ST_ADDR) eng_wdata_d = {addr_q, rw_q};
    end
    if (cmd_done) pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = slave_addr;
          rw_d        = rw;
          cnt_d       = byte_count;
          err_d       = 2'b00;
          busy_d      = 1'b1;
          state_d     = ST_START;
          eng_valid_d = 1'b1;
          eng_cmd_d   = CMD_START;
          eng_last_d  = 1'b0;
        end
      end
      ST_START: if (cmd_done) state_d = ST_ADDR;
      ST_ADDR: begin
        if (cmd_done) begin
          if (eng_nack) begin
            err_d   = 2'b01;
            state_d = ST_STOP;
          end else if (cnt_q == '0) begin
            state_d = ST_STOP;
          end else begin
            state_d = rw_q ? ST_WAIT_RX : ST_WAIT_TX;
          end
        end
      end
      ST_WAIT_TX: begin
        if (!tx_empty) begin
          tx_rd_en_d  = 1'b1;
          eng_wdata_d = tx_data;
          state_d     = ST_WRITE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = 2'b11;
          state_d = ST_STOP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_WRITE: begin
        if (cmd_done) begin
          if (eng_nack) begin
            err_d   = 2'b10;
            state_d = ST_STOP;
          end else begin
            cnt_d   = cnt_q - CNT_WIDTH'(1);
            state_d = last_byte ? ST_STOP : ST_WAIT_TX;
          end
        end
      end
      ST_WAIT_RX: if (!rx_full) state_d = ST_READ;
      ST_READ: begin
        if (cmd_done) begin
          rx_data_d  = eng_rdata;
          rx_wr_en_d = 1'b1;
          cnt_d      = cnt_q - CNT_WIDTH'(1);
          state_d    = last_byte ? ST_STOP : ST_WAIT_RX;
        end
      end
      ST_STOP: begin
        if (cmd_done) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
      eng_valid_q <= 1'b0;
      eng_cmd_q   <= 2'b00;
      eng_wdata_q <= '0;
      eng_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      tx_rd_en_q  <= 1'b0;
      rx_wr_en_q  <= 1'b0;
      rx_data_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      eng_valid_q <= eng_valid_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_wdata_q <= eng_wdata_d;
      eng_last_q  <= eng_last_d;
      pend_q      <= pend_d;
      tx_rd_en_q  <= tx_rd_en_d;
      rx_wr_en_q  <= rx_wr_en_d;
      rx_data_q   <= rx_data_d;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign tx_rd_en  = tx_rd_en_q;
  assign rx_wr_en  = rx_wr_en_q;
  assign rx_data   = rx_data_q;
  assign eng_valid = eng_valid_q;
  assign eng_cmd   = eng_cmd_q;
  assign eng_wdata = eng_wdata_q;
  assign eng_last  = eng_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_i2c_fifo_sequencer.sv
// Directed bench for i2c_fifo_sequencer: behavioural engine, TX FIFO and RX sink,
// with hand-computed command/data expectations checked by immediate assertions.
`timescale 1ns/1ps
module tb_i2c_fifo_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       start;
  logic [6:0] slave_addr;
  logic       rw;
  logic [7:0] byte_count;
  logic       tx_empty = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_rd_en;
  logic       rx_full;
  logic       rx_wr_en;
  logic [7:0] rx_data;
  logic       eng_valid;
  logic [1:0] eng_cmd;
  logic [7:0] eng_wdata;
  logic       eng_last;
  logic       eng_ready;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rdata = 8'h00;
  logic       eng_nack = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  i2c_fifo_sequencer #(.CNT_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .slave_addr(slave_addr), .rw(rw),
    .byte_count(byte_count), .tx_empty(tx_empty), .tx_data(tx_data), .tx_rd_en(tx_rd_en),
    .rx_full(rx_full), .rx_wr_en(rx_wr_en), .rx_data(rx_data), .eng_valid(eng_valid),
    .eng_cmd(eng_cmd), .eng_wdata(eng_wdata), .eng_last(eng_last), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_nack(eng_nack), .busy(busy),
    .done(done), .err_code(err_code)
  );

  always #5 PCLK = ~PCLK;

  // Stimulus-side data (written by the initial block only)
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  int         nack_idx = -1;

  // Model-side state (written by the responder only)
  logic [1:0] log_cmd[$];
  logic [7:0] log_wd[$];
  logic       log_last[$];
  logic [7:0] rx_log[$];
  int         tx_ptr = 0;
  int         rd_ptr = 0;
  int         countdown = 0;
  int         pend_idx = 0;
  logic [1:0] pend_cmd = 2'b00;

  int errors = 0;
  int checks = 0;

  // Engine answers two cycles after acceptance; FIFO pops/pushes are tracked here.
  always @(negedge PCLK) begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (countdown > 0) begin
      countdown = countdown - 1;
      if (countdown == 0) begin
        eng_done = 1'b1;
        eng_nack = (pend_idx == nack_idx);
        if (pend_cmd == 2'b10) begin
          eng_rdata = (rd_ptr < rd_q.size()) ? rd_q[rd_ptr] : 8'h00;
          rd_ptr = rd_ptr + 1;
        end
      end
    end
    if (eng_valid && eng_ready) begin
      pend_idx = log_cmd.size();
      pend_cmd = eng_cmd;
      log_cmd.push_back(eng_cmd);
      log_wd.push_back(eng_wdata);
      log_last.push_back(eng_last);
      countdown = 2;
    end
    if (tx_rd_en) tx_ptr = tx_ptr + 1;
    if (rx_wr_en) rx_log.push_back(rx_data);
    tx_empty = (tx_ptr >= tx_q.size());
    tx_data  = tx_empty ? 8'h00 : tx_q[tx_ptr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic do_start(input logic [6:0] a, input logic r, input logic [7:0] c);
    slave_addr = a;
    rw         = r;
    byte_count = c;
    start      = 1'b1;
    @(negedge PCLK);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge PCLK);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge PCLK);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  int  b, p, r;
  bit  found;
`ifdef SEQ_TIMEOUT_EN
  int  lat;
`endif

  initial begin
    PRESET = 1'b1; start = 1'b0; slave_addr = 7'h0; rw = 1'b0; byte_count = 8'h0;
    rx_full = 1'b0; eng_ready = 1'b1;
    cycles(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(eng_valid), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_txrd", 32'(tx_rd_en), 32'd0);
    check("rst_rxwr", 32'(rx_wr_en), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    PRESET = 1'b0;
    cycles(2);

    // Write two bytes
    tx_q.push_back(8'h55); tx_q.push_back(8'hF5);
    b = log_cmd.size(); p = tx_ptr; r = rx_log.size();
    do_start(7'h50, 1'b0, 8'd2);
    check("wr2_start_busy", 32'(busy), 32'd1);
    check("wr2_start_valid", 32'(eng_valid), 32'd1);
    check("wr2_start_cmd", 32'(eng_cmd), 32'd0);
    wait_done("wr2");
    check("wr2_ncmd", 32'(log_cmd.size() - b), 32'd5);
    check("wr2_c0", 32'(log_cmd[b]), 32'd0);
    check("wr2_c1", 32'(log_cmd[b+1]), 32'd1);
    check("wr2_w1", 32'(log_wd[b+1]), 32'hA0);
    check("wr2_c2", 32'(log_cmd[b+2]), 32'd1);
    check("wr2_w2", 32'(log_wd[b+2]), 32'h55);
    check("wr2_c3", 32'(log_cmd[b+3]), 32'd1);
    check("wr2_w3", 32'(log_wd[b+3]), 32'hF5);
    check("wr2_c4", 32'(log_cmd[b+4]), 32'd3);
    check("wr2_pops", 32'(tx_ptr - p), 32'd2);
    check("wr2_push", 32'(rx_log.size() - r), 32'd0);
    check("wr2_err", 32'(err_code), 32'd0);

    // Read three bytes
    rd_q.push_back(8'hAA); rd_q.push_back(8'hFA); rd_q.push_back(8'h11);
    b = log_cmd.size(); p = tx_ptr; r = rx_log.size();
    do_start(7'h50, 1'b1, 8'd3);
    wait_done("rd3");
    check("rd3_ncmd", 32'(log_cmd.size() - b), 32'd6);
    check("rd3_addr", 32'(log_wd[b+1]), 32'hA1);
    check("rd3_c2", 32'(log_cmd[b+2]), 32'd2);
    check("rd3_c3", 32'(log_cmd[b+3]), 32'd2);
    check("rd3_c4", 32'(log_cmd[b+4]), 32'd2);
    check("rd3_l2", 32'(log_last[b+2]), 32'd0);
    check("rd3_l3", 32'(log_last[b+3]), 32'd0);
    check("rd3_l4", 32'(log_last[b+4]), 32'd1);
    check("rd3_c5", 32'(log_cmd[b+5]), 32'd3);
    check("rd3_npush", 32'(rx_log.size() - r), 32'd3);
    check("rd3_d0", 32'(rx_log[r]), 32'hAA);
    check("rd3_d1", 32'(rx_log[r+1]), 32'hFA);
    check("rd3_d2", 32'(rx_log[r+2]), 32'h11);
    check("rd3_err", 32'(err_code), 32'd0);

    // Address NACK on a read
    b = log_cmd.size(); p = tx_ptr; r = rx_log.size();
    nack_idx = b + 1;
    do_start(7'h50, 1'b1, 8'd2);
    wait_done("nak");
    nack_idx = -1;
    check("nak_ncmd", 32'(log_cmd.size() - b), 32'd3);
    check("nak_stop", 32'(log_cmd[b+2]), 32'd3);
    check("nak_push", 32'(rx_log.size() - r), 32'd0);
    check("nak_pops", 32'(tx_ptr - p), 32'd0);
    check("nak_err", 32'(err_code), 32'd1);

    // Read with RX FIFO full for a while
    rd_q.push_back(8'h3C);
    rx_full = 1'b1;
    b = log_cmd.size(); r = rx_log.size();
    do_start(7'h50, 1'b1, 8'd1);
    check("rbp_err_clr", 32'(err_code), 32'd0);
    cycles(16);
    check("rbp_stall_ncmd", 32'(log_cmd.size() - b), 32'd2);
    check("rbp_stall_busy", 32'(busy), 32'd1);
    rx_full = 1'b0;
    wait_done("rbp");
    check("rbp_ncmd", 32'(log_cmd.size() - b), 32'd4);
    check("rbp_read", 32'(log_cmd[b+2]), 32'd2);
    check("rbp_last", 32'(log_last[b+2]), 32'd1);
    check("rbp_data", 32'(rx_log[r]), 32'h3C);

    // Write with TX FIFO empty; a start during the stall must be ignored
    b = log_cmd.size(); p = tx_ptr; r = rx_log.size();
    do_start(7'h50, 1'b0, 8'd1);
    cycles(6);
    do_start(7'h7F, 1'b1, 8'd5);
    cycles(10);
    check("wbp_stall_ncmd", 32'(log_cmd.size() - b), 32'd2);
    check("wbp_stall_pops", 32'(tx_ptr - p), 32'd0);
    tx_q.push_back(8'h7E);
    wait_done("wbp");
    check("wbp_ncmd", 32'(log_cmd.size() - b), 32'd4);
    check("wbp_addr", 32'(log_wd[b+1]), 32'hA0);
    check("wbp_data", 32'(log_wd[b+2]), 32'h7E);
    check("wbp_stop", 32'(log_cmd[b+3]), 32'd3);
    check("wbp_pops", 32'(tx_ptr - p), 32'd1);
    check("wbp_push", 32'(rx_log.size() - r), 32'd0);

    // Zero-length transaction
    b = log_cmd.size(); p = tx_ptr;
    do_start(7'h21, 1'b0, 8'd0);
    wait_done("z0");
    check("z0_ncmd", 32'(log_cmd.size() - b), 32'd3);
    check("z0_addr", 32'(log_wd[b+1]), 32'h42);
    check("z0_stop", 32'(log_cmd[b+2]), 32'd3);
    check("z0_pops", 32'(tx_ptr - p), 32'd0);

    // Reset while the first data WRITE is requested
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    p = tx_ptr;
    found = 1'b0;
    do_start(7'h50, 1'b0, 8'd2);
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge PCLK);
      if (eng_valid === 1'b1 && eng_cmd === 2'b01 && tx_ptr == p + 1) found = 1'b1;
    end
    check("rst_mid_found", 32'(found), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(eng_valid), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_txrd", 32'(tx_rd_en), 32'd0);
    cycles(6);
    b = log_cmd.size(); p = tx_ptr;
    do_start(7'h50, 1'b0, 8'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_done("post_rst");
    check("post_rst_ncmd", 32'(log_cmd.size() - b), 32'd4);
    check("post_rst_data", 32'(log_wd[b+2]), 32'h34);
    check("post_rst_pops", 32'(tx_ptr - p), 32'd1);
    check("post_rst_err", 32'(err_code), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // TX stall timeout: 16 WAIT_TX cycles, then STOP
    b = log_cmd.size(); p = tx_ptr;
    lat = 0;
    do_start(7'h50, 1'b0, 8'd1);
    for (int i = 1; i <= 300 && lat == 0; i++) begin
      @(negedge PCLK);
      if (done === 1'b1) lat = i;
    end
    check("to_latency", 32'(lat), 32'd27);
    check("to_err", 32'(err_code), 32'd3);
    check("to_ncmd", 32'(log_cmd.size() - b), 32'd3);
    check("to_stop", 32'(log_cmd[b+2]), 32'd3);
    check("to_pops", 32'(tx_ptr - p), 32'd0);
    cycles(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
